vin_timing_detect: RTL and testbench

Video input timing detector, the receive-side counterpart of the display timing generator. It sits on a captured video stream running on `dp_clk` and measures the horizontal and vertical timing from incoming `hs`/`vs`/`de`. It publishes the measured geometry, a lock flag and per-pixel x/y coordinates. Downstream logic uses the results to auto-configure the output timing generator and to address line buffers.

---
 rtl/vin_timing_detect.sv | 159 +++++++++++++++
 tb/tb_vin_timing_detect.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vin_timing_detect.sv
// Video input timing detector: measures hs/vs/de geometry from a captured stream,
// tracks frame-to-frame lock and emits per-pixel x/y aligned with a delayed de.
module vin_timing_detect #(
  parameter int unsigned CNT_W  = 12,
  parameter bit          HS_POL = 1'b1,
  parameter bit          VS_POL = 1'b1
) (
  input  logic             dp_clk,
  input  logic             rst_n,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic             de_in,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_sync,
  output logic [CNT_W-1:0] h_start,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_sync,
  output logic [CNT_W-1:0] v_active,
  output logic             meas_valid,
  output logic             locked,
  output logic             frame_start,
  output logic             de_o,
  output logic [CNT_W-1:0] x_pos,
  output logic [CNT_W-1:0] y_pos
);
  localparam int unsigned      SET_W   = 7 * CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [1:0]       SEEK    = 2'd0;
  localparam logic [1:0]       MEAS    = 2'd1;
  localparam logic [1:0]       CHECK   = 2'd2;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  logic             hs_r_q, hs_r2_q, vs_r_q, vs_r2_q, de_r_q, de_r2_q;
  logic             hs_r_d, vs_r_d, de_r_d;
  logic [CNT_W-1:0] h_run_q, h_run_d, hs_cnt_q, hs_cnt_d, de_cnt_q, de_cnt_d;
  logic [CNT_W-1:0] h_total_cap_q, h_total_cap_d, h_sync_cap_q, h_sync_cap_d;
  logic [CNT_W-1:0] h_start_cap_q, h_start_cap_d, h_active_cap_q, h_active_cap_d;
  logic [CNT_W-1:0] v_run_q, v_run_d, vsl_cnt_q, vsl_cnt_d, dl_cnt_q, dl_cnt_d;
  logic [CNT_W-1:0] v_sync_cap_q, v_sync_cap_d, v_total_new;
  logic [1:0]       state_q, state_d;
  logic             meas_valid_q, meas_valid_d, locked_q, locked_d;
  logic             frame_start_q, frame_start_d, de_o_q, de_o_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic [SET_W-1:0] pub_q, pub_d, new_set;
  logic             hs_rise, hs_fall, vs_rise, vs_fall, de_rise, de_fall, timeout;

  assign hs_r_d  = ~(hs_in ^ HS_POL);
  assign vs_r_d  = ~(vs_in ^ VS_POL);
  assign de_r_d  = de_in;
  assign hs_rise = hs_r_q & ~hs_r2_q;
  assign hs_fall = ~hs_r_q & hs_r2_q;
  assign vs_rise = vs_r_q & ~vs_r2_q;
  assign vs_fall = ~vs_r_q & vs_r2_q;
  assign de_rise = de_r_q & ~de_r2_q;
  assign de_fall = ~de_r_q & de_r2_q;

  // A saturated counter that is not being cleared this cycle means the stream stalled.
  assign timeout = ((h_run_q == CNT_MAX) && !hs_rise) || ((v_run_q == CNT_MAX) && !vs_rise);

  assign new_set = {h_total_cap_d, h_sync_cap_d, h_start_cap_d, h_active_cap_d,
                    v_total_new, v_sync_cap_d, dl_cnt_q};

  // Line and frame measurement counters with their capture registers.
  always_comb begin
    h_run_d        = hs_rise ? '0 : sat_inc(h_run_q);
    h_total_cap_d  = hs_rise ? CNT_W'(h_run_q + CNT_ONE) : h_total_cap_q;
    hs_cnt_d       = hs_rise ? CNT_ONE : (hs_r_q ? sat_inc(hs_cnt_q) : hs_cnt_q);
    h_sync_cap_d   = hs_fall ? hs_cnt_q : h_sync_cap_q;
    h_start_cap_d  = de_rise ? CNT_W'(h_run_q + CNT_ONE) : h_start_cap_q;
    de_cnt_d       = de_rise ? CNT_ONE : (de_r_q ? sat_inc(de_cnt_q) : de_cnt_q);
    h_active_cap_d = de_fall ? de_cnt_q : h_active_cap_q;
    v_total_new    = hs_rise ? CNT_W'(v_run_q + CNT_ONE) : v_run_q;
    v_run_d        = v_run_q;
    vsl_cnt_d      = vsl_cnt_q;
    dl_cnt_d       = dl_cnt_q;
    if (vs_rise) begin
      v_run_d   = '0;
      vsl_cnt_d = hs_rise ? CNT_ONE : '0;
      dl_cnt_d  = de_rise ? CNT_ONE : '0;
    end else begin
      if (hs_rise)          v_run_d   = sat_inc(v_run_q);
      if (hs_rise && vs_r_q) vsl_cnt_d = sat_inc(vsl_cnt_q);
      if (de_rise)          dl_cnt_d  = sat_inc(dl_cnt_q);
    end
    v_sync_cap_d   = vs_fall ? vsl_cnt_q : v_sync_cap_q;
  end

  // Lock FSM, publish registers and coordinate outputs.
  always_comb begin
    state_d       = state_q;
    meas_valid_d  = meas_valid_q;
    locked_d      = locked_q;
    pub_d         = pub_q;
    frame_start_d = vs_rise;
    de_o_d        = de_r_q;
    x_d           = de_rise ? '0 : (de_r_q ? sat_inc(x_q) : x_q);
    y_d           = vs_rise ? '0 : (de_fall ? sat_inc(y_q) : y_q);
    if (timeout) begin
      state_d      = SEEK;
      meas_valid_d = 1'b0;
      locked_d     = 1'b0;
    end else if (vs_rise) begin
      case (state_q)
        SEEK: state_d = MEAS;
        MEAS: begin
          pub_d        = new_set;
          meas_valid_d = 1'b1;
          state_d      = CHECK;
        end
        CHECK: begin
          locked_d = (new_set == pub_q);
          pub_d    = new_set;
        end
        default: state_d = SEEK;
      endcase
    end
  end

  always_ff @(posedge dp_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_r_q <= 1'b0; hs_r2_q <= 1'b0; vs_r_q <= 1'b0; vs_r2_q <= 1'b0;
      de_r_q <= 1'b0; de_r2_q <= 1'b0;
      h_run_q <= '0; hs_cnt_q <= '0; de_cnt_q <= '0;
      h_total_cap_q <= '0; h_sync_cap_q <= '0; h_start_cap_q <= '0; h_active_cap_q <= '0;
      v_run_q <= '0; vsl_cnt_q <= '0; dl_cnt_q <= '0; v_sync_cap_q <= '0;
      state_q <= SEEK; meas_valid_q <= 1'b0; locked_q <= 1'b0; pub_q <= '0;
      frame_start_q <= 1'b0; de_o_q <= 1'b0; x_q <= '0; y_q <= '0;
    end else begin
      hs_r_q <= hs_r_d; hs_r2_q <= hs_r_q; vs_r_q <= vs_r_d; vs_r2_q <= vs_r_q;
      de_r_q <= de_r_d; de_r2_q <= de_r_q;
      h_run_q <= h_run_d; hs_cnt_q <= hs_cnt_d; de_cnt_q <= de_cnt_d;
      h_total_cap_q <= h_total_cap_d; h_sync_cap_q <= h_sync_cap_d;
      h_start_cap_q <= h_start_cap_d; h_active_cap_q <= h_active_cap_d;
      v_run_q <= v_run_d; vsl_cnt_q <= vsl_cnt_d; dl_cnt_q <= dl_cnt_d;
      v_sync_cap_q <= v_sync_cap_d;
      state_q <= state_d; meas_valid_q <= meas_valid_d; locked_q <= locked_d; pub_q <= pub_d;
      frame_start_q <= frame_start_d; de_o_q <= de_o_d; x_q <= x_d; y_q <= y_d;
    end
  end

  assign h_total     = pub_q[6*CNT_W +: CNT_W];
  assign h_sync      = pub_q[5*CNT_W +: CNT_W];
  assign h_start     = pub_q[4*CNT_W +: CNT_W];
  assign h_active    = pub_q[3*CNT_W +: CNT_W];
  assign v_total     = pub_q[2*CNT_W +: CNT_W];
  assign v_sync      = pub_q[1*CNT_W +: CNT_W];
  assign v_active    = pub_q[0 +: CNT_W];
  assign meas_valid  = meas_valid_q;
  assign locked      = locked_q;
  assign frame_start = frame_start_q;
  assign de_o        = de_o_q;
  assign x_pos       = x_q;
  assign y_pos       = y_q;
endmodule

// File: tb/tb_vin_timing_detect.sv
// Bench for vin_timing_detect: frame table with per-vs-rise expectations, scoreboard
// checked at frame_start, plus stall/reset/latency sequences; a second DUT uses inverted syncs.
module tb_vin_timing_detect;
  localparam int unsigned CNT_W = 12;
  localparam int H_SYNC = 4, H_BP = 8, H_TOT = 48;
  localparam int V_SYNC = 2, V_BP = 3, V_ACT = 10, V_TOT = 17;

  // mode: 0 normal frame, 1 stream stall before the frame, 2 reset pulse inside the frame
  typedef struct { int hact; int mode; int mv; int lk; int ha; int gap; } row_t;
  typedef struct { int mv; int lk; int ha; int gap; } exp_t;

  logic dp_clk = 1'b0;
  logic rst_n, hs, vs, de;
  logic [CNT_W-1:0] h_total, h_sync, h_start, h_active, v_total, v_sync, v_active, x_pos, y_pos;
  logic meas_valid, locked, frame_start, de_o;
  logic [CNT_W-1:0] h_total2, h_sync2, h_start2, h_active2, v_total2, v_sync2, v_active2, x_pos2, y_pos2;
  logic meas_valid2, locked2, frame_start2, de_o2;
  logic any_out;

  int n_checks = 0, n_err = 0;
  int gen_hact = 32, mv_before = 0, lk_before = 0;
  int cyc = 0, last_fs = -1, y_exp = 0, last_x = 0, last_y = 0;
  bit coord_en = 1'b0, de_prev = 1'b0;
  exp_t sb[$];
  row_t rows[16];

  always #5 dp_clk = ~dp_clk;

  vin_timing_detect #(.CNT_W(CNT_W), .HS_POL(1'b1), .VS_POL(1'b1)) dut (
    .dp_clk(dp_clk), .rst_n(rst_n), .hs_in(hs), .vs_in(vs), .de_in(de),
    .h_total(h_total), .h_sync(h_sync), .h_start(h_start), .h_active(h_active),
    .v_total(v_total), .v_sync(v_sync), .v_active(v_active),
    .meas_valid(meas_valid), .locked(locked), .frame_start(frame_start),
    .de_o(de_o), .x_pos(x_pos), .y_pos(y_pos));

  vin_timing_detect #(.CNT_W(CNT_W), .HS_POL(1'b0), .VS_POL(1'b0)) dut_inv (
    .dp_clk(dp_clk), .rst_n(rst_n), .hs_in(~hs), .vs_in(~vs), .de_in(de),
    .h_total(h_total2), .h_sync(h_sync2), .h_start(h_start2), .h_active(h_active2),
    .v_total(v_total2), .v_sync(v_sync2), .v_active(v_active2),
    .meas_valid(meas_valid2), .locked(locked2), .frame_start(frame_start2),
    .de_o(de_o2), .x_pos(x_pos2), .y_pos(y_pos2));

  assign any_out = |{h_total, h_sync, h_start, h_active, v_total, v_sync, v_active, x_pos, y_pos,
                     meas_valid, locked, frame_start, de_o,
                     h_total2, h_sync2, h_start2, h_active2, v_total2, v_sync2, v_active2,
                     x_pos2, y_pos2, meas_valid2, locked2, frame_start2, de_o2};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_set(input string tag, input logic [CNT_W-1:0] ht, hy, hst, ha, vt, vy, va,
                         input logic mv, lk, input exp_t e);
    bit z;
    z = (e.ha == 0);
    check({tag, "h_total"},  int'(ht),  z ? 0 : H_TOT);
    check({tag, "h_sync"},   int'(hy),  z ? 0 : H_SYNC);
    check({tag, "h_start"},  int'(hst), z ? 0 : H_SYNC + H_BP);
    check({tag, "h_active"}, int'(ha),  e.ha);
    check({tag, "v_total"},  int'(vt),  z ? 0 : V_TOT);
    check({tag, "v_sync"},   int'(vy),  z ? 0 : V_SYNC);
    check({tag, "v_active"}, int'(va),  z ? 0 : V_ACT);
    check({tag, "meas_valid"}, int'(mv), e.mv);
    check({tag, "locked"},     int'(lk), e.lk);
  endtask

  task automatic send_frame(input row_t r);
    exp_t e;
    gen_hact = r.hact;
    for (int l = 0; l < V_TOT; l++) begin
      for (int c = 0; c < H_TOT; c++) begin
        @(negedge dp_clk);
        if (l == 0 && c == 0) begin
          e.mv = r.mv; e.lk = r.lk; e.ha = r.ha; e.gap = r.gap;
          sb.push_back(e);
        end
        if (l == 0 && c == 1) begin
          check("fs_early", int'(frame_start), 0);
          check("mv_before_publish", int'(meas_valid), mv_before);
          check("lk_before_publish", int'(locked), lk_before);
        end
        if (l == 0 && c == 2) begin
          check("fs_latency", int'(frame_start), 1);
          mv_before = r.mv;
          lk_before = r.lk;
        end
        if (l == 0 && c == 3) check("fs_one_cycle", int'(frame_start), 0);
        if (r.mode == 2 && l == 8) begin
          if (c == 20) rst_n = 1'b0;
          if (c == 21 || c == 22) check("outputs_in_reset", int'(any_out), 0);
          if (c == 23) begin
            rst_n = 1'b1;
            mv_before = 0;
            lk_before = 0;
          end
        end
        hs = (c < H_SYNC);
        vs = (l < V_SYNC);
        de = (l >= V_SYNC + V_BP) && (l < V_SYNC + V_BP + V_ACT) &&
             (c >= H_SYNC + H_BP) && (c < H_SYNC + H_BP + r.hact);
      end
    end
  endtask

  // Scoreboard and coordinate monitor.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge dp_clk);
      cyc++;
      if (!rst_n) begin
        coord_en = 1'b0;
        last_fs  = -1;
        de_prev  = 1'b0;
      end else begin
        if (frame_start) begin
          if (sb.size() == 0) begin
            check("sb_unexpected_frame_start", 1, 0);
          end else begin
            e = sb.pop_front();
            cmp_set("pub.", h_total, h_sync, h_start, h_active, v_total, v_sync, v_active,
                    meas_valid, locked, e);
            cmp_set("inv.", h_total2, h_sync2, h_start2, h_active2, v_total2, v_sync2, v_active2,
                    meas_valid2, locked2, e);
            if (e.gap != 0 && last_fs >= 0) check("fs_period", cyc - last_fs, e.gap);
          end
          if (coord_en) check("y_last_line", last_y, V_ACT - 1);
          check("inv_frame_start", int'(frame_start2), 1);
          coord_en = 1'b1;
          y_exp    = 0;
          last_fs  = cyc;
        end
        if (coord_en) begin
          if (de_o && !de_prev) begin
            check("x_first", int'(x_pos), 0);
            check("y_line", int'(y_pos), y_exp);
          end
          if (!de_o && de_prev) begin
            check("x_last", last_x, gen_hact - 1);
            y_exp++;
          end
          if (de_o) begin
            last_x = int'(x_pos);
            last_y = int'(y_pos);
          end
        end
        de_prev = de_o;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1);
  end

  initial begin : main
    rows[0]  = '{32, 0, 0, 0, 0,  0};
    rows[1]  = '{32, 0, 1, 0, 32, 816};
    rows[2]  = '{32, 0, 1, 1, 32, 816};
    rows[3]  = '{32, 0, 1, 1, 32, 816};
    rows[4]  = '{30, 0, 1, 1, 32, 816};
    rows[5]  = '{32, 0, 1, 0, 30, 816};
    rows[6]  = '{32, 0, 1, 0, 32, 816};
    rows[7]  = '{32, 0, 1, 1, 32, 816};
    rows[8]  = '{32, 1, 0, 0, 32, 0};
    rows[9]  = '{32, 0, 1, 0, 32, 816};
    rows[10] = '{32, 0, 1, 1, 32, 816};
    rows[11] = '{32, 2, 1, 1, 32, 816};
    rows[12] = '{32, 0, 0, 0, 0,  0};
    rows[13] = '{32, 0, 1, 0, 32, 816};
    rows[14] = '{32, 0, 1, 1, 32, 816};
    rows[15] = '{32, 0, 1, 1, 32, 816};

    rst_n = 1'b0; hs = 1'b0; vs = 1'b0; de = 1'b0;
    repeat (3) @(negedge dp_clk);
    check("reset_state", int'(any_out), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge dp_clk);

    for (int i = 0; i < 16; i++) begin
      if (rows[i].mode == 1) begin
        repeat (3900) @(negedge dp_clk);
        check("stall_mv_still_valid", int'(meas_valid), 1);
        repeat (300) @(negedge dp_clk);
        check("stall_mv_cleared", int'(meas_valid), 0);
        check("stall_lk_cleared", int'(locked), 0);
        check("stall_inv_mv_cleared", int'(meas_valid2), 0);
        mv_before = 0;
        lk_before = 0;
      end
      send_frame(rows[i]);
    end

    repeat (10) @(negedge dp_clk);
    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
